rsa2048_ahb_ctrl: RTL and testbench

AHB-Lite slave controller that sequences one RSA-2048 modular-exponentiation core. It arms an operation, streams WORDS 32-bit operand words LSW-first into the core, and starts the core. It then reports completion through a status register and IRQ, and streams the WORDS result words back out through a single data port. It sits between the system AHB matrix and the rsa2048 datapath and replaces direct bus access to the core.

---
 rtl/rsa2048_ctrl_pkg.sv | 37 +++
 rtl/rsa2048_ahb_slv_if.sv | 64 ++++++
 rtl/rsa2048_ahb_ctrl.sv | 149 ++++++++++++++
 tb/tb_rsa2048_ahb_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa2048_ctrl_pkg.sv
// Shared definitions for the RSA-2048 AHB-Lite controller.
// Contents: register byte offsets, CTRL/STATUS bit positions, the
// sequencing state enum and the AHB HTRANS/HSIZE encodings.
package rsa2048_ctrl_pkg;

  // Register byte offsets; only HADDR[4:2] is decoded.
  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h04;
  localparam logic [4:0] REG_DATA   = 5'h10;

  // CTRL bits
  localparam int CTRL_ARM = 0;
  localparam int CTRL_IE  = 1;

  // STATUS bits
  localparam int ST_DONE    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_LOAD    = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_CNT_LSB = 8;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

endpackage

// File: rtl/rsa2048_ahb_slv_if.sv
// AHB-Lite address-phase capture for the RSA-2048 controller.
// Registers offset/write/size when a NONSEQ or SEQ transfer is selected
// while HREADYIN is high, and decodes the data-phase strobes.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   HSEL, HREADYIN, HADDR, HTRANS, HWRITE, HSIZE   AHB address phase
//   wr_ctrl   data phase is a CTRL write
//   rd_ctrl   data phase is a CTRL read
//   rd_status data phase is a STATUS read
//   wr_data   data phase is a DATA write
//   rd_data   data phase is a DATA read
//   size_ok   captured HSIZE is a 32-bit word
module rsa2048_ahb_slv_if
  import rsa2048_ctrl_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADYIN,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  output logic        wr_ctrl,
  output logic        rd_ctrl,
  output logic        rd_status,
  output logic        wr_data,
  output logic        rd_data,
  output logic        size_ok
);

  logic       dp_valid;
  logic [2:0] dp_off;
  logic       dp_write;
  logic [2:0] dp_size;
  logic [4:0] dp_byte;
  logic       sig_unused;

  // HREADYIN low means the current data phase is still stalled, so the
  // pending address phase must not be taken yet.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_off   <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
    end else if (HREADYIN) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_off   <= HADDR[4:2];
      dp_write <= HWRITE;
      dp_size  <= HSIZE;
    end
  end

  assign dp_byte    = {dp_off, 2'b00};
  assign wr_ctrl    = dp_valid &  dp_write & (dp_byte == REG_CTRL);
  assign rd_ctrl    = dp_valid & ~dp_write & (dp_byte == REG_CTRL);
  assign rd_status  = dp_valid & ~dp_write & (dp_byte == REG_STATUS);
  assign wr_data    = dp_valid &  dp_write & (dp_byte == REG_DATA);
  assign rd_data    = dp_valid & ~dp_write & (dp_byte == REG_DATA);
  assign size_ok    = (dp_size == HSIZE_WORD);
  assign sig_unused = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

endmodule

// File: rtl/rsa2048_ahb_ctrl.sv
// AHB-Lite slave sequencing one RSA-2048 modular-exponentiation core:
// arm, stream WORDS operand words in, start, wait for done, stream WORDS
// result words out.
// Handshake: an operand word moves on a cycle with x_wvalid & x_wready;
// a result word moves on a cycle with r_rvalid & r_rready. Each bus data
// phase completes on the cycle HREADYOUT is high, which for DATA is
// exactly the core handshake cycle, so each word is counted once.
// Ports: AHB-Lite slave (HCLK..HRESP), IRQ (level), operand stream
// (x_*), core_start/core_abort pulses, core_done, result stream (r_*),
// dbg_state (current sequencing state).
module rsa2048_ahb_ctrl
  import rsa2048_ctrl_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADYIN,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic        IRQ,
  output logic        x_wvalid,
  output logic [31:0] x_wdata,
  input  logic        x_wready,
  output logic        core_start,
  output logic        core_abort,
  input  logic        core_done,
  input  logic        r_rvalid,
  input  logic [31:0] r_rdata,
  output logic        r_rready,
  output logic [2:0]  dbg_state
);

  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);

  state_t      state;
  logic [6:0]  count;
  logic        ie;
  logic        err;

  logic        wr_ctrl, rd_ctrl, rd_status, wr_data, rd_data, size_ok;
  logic        done_st, wr_ok, rd_ok, data_bad, arm, wr_xfer, rd_xfer;
  logic [31:0] status_word;

  rsa2048_ahb_slv_if u_slv_if (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADYIN  (HREADYIN),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .wr_ctrl   (wr_ctrl),
    .rd_ctrl   (rd_ctrl),
    .rd_status (rd_status),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .size_ok   (size_ok)
  );

  assign done_st  = (state == S_DONE) || (state == S_UNLOAD);
  // Legal DATA accesses; anything else on DATA only raises ERR and
  // completes zero-wait.
  assign wr_ok    = wr_data & size_ok & (state == S_LOAD);
  assign rd_ok    = rd_data & size_ok & done_st;
  assign data_bad = (wr_data | rd_data) & ~(wr_ok | rd_ok);
  assign arm      = wr_ctrl & HWDATA[CTRL_ARM];
  assign wr_xfer  = wr_ok & x_wready;
  assign rd_xfer  = rd_ok & r_rvalid;

  assign status_word = {17'b0, count, 4'b0, err, (state == S_LOAD),
                        (state == S_RUN), done_st};

  assign x_wvalid  = wr_ok;
  assign x_wdata   = wr_ok ? HWDATA : 32'h0;
  assign r_rready  = rd_xfer;
  assign HREADYOUT = wr_ok ? x_wready : (rd_ok ? r_rvalid : 1'b1);
  assign HRESP     = 2'b00;
  assign IRQ       = done_st & ie;
  assign dbg_state = state;

  always_comb begin
    HRDATA = 32'h0;
    if (rd_ok)          HRDATA = r_rdata;
    else if (rd_ctrl)   HRDATA = {30'b0, ie, 1'b0};
    else if (rd_status) HRDATA = status_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      count      <= '0;
      ie         <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      if (wr_ctrl)  ie  <= HWDATA[CTRL_IE];
      if (data_bad) err <= 1'b1;
      // ARM wins over everything, including a core_done in the same cycle.
      if (arm) begin
        count      <= '0;
        err        <= 1'b0;
        state      <= S_LOAD;
        core_abort <= (state == S_RUN);
      end else begin
        case (state)
          S_LOAD: begin
            if (wr_xfer) begin
              if (count == LAST_IDX) begin
                count      <= '0;
                core_start <= 1'b1;
                state      <= S_RUN;
              end else begin
                count <= count + 7'd1;
              end
            end
          end
          S_RUN: begin
            if (core_done) state <= S_DONE;
          end
          S_DONE, S_UNLOAD: begin
            if (rd_xfer) begin
              if (count == LAST_IDX) begin
                count <= '0;
                state <= S_IDLE;
              end else begin
                count <= count + 7'd1;
                state <= S_UNLOAD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa2048_ahb_ctrl.sv
// Directed bench for rsa2048_ahb_ctrl with queue-based scoreboards for
// operand words and bus read data.
module tb_rsa2048_ahb_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADYIN;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic        IRQ;
  logic        x_wvalid;
  logic [31:0] x_wdata;
  logic        x_wready;
  logic        core_start;
  logic        core_abort;
  logic        core_done;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_rready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];

  rsa2048_ahb_ctrl #(.WORDS(64)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HREADYIN   (HREADYIN),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .IRQ        (IRQ),
    .x_wvalid   (x_wvalid),
    .x_wdata    (x_wdata),
    .x_wready   (x_wready),
    .core_start (core_start),
    .core_abort (core_abort),
    .core_done  (core_done),
    .r_rvalid   (r_rvalid),
    .r_rdata    (r_rdata),
    .r_rready   (r_rready),
    .dbg_state  (dbg_state)
  );

  // Single-slave system: the bus ready seen by the slave is its own.
  assign HREADYIN = HREADYOUT;

  // ---------------- clock / timeout ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- result-word source ----------------
  int   ridx = 0;
  logic rtake = 1'b0;
  always @(negedge HCLK) rtake = r_rvalid & r_rready;
  always @(posedge HCLK) begin
    if (rtake) ridx = ridx + 1;
    r_rdata = 32'hA500_0000 + 32'(ridx);
  end

  // ---------------- monitors / scoreboard ----------------
  logic tb_dp_rd;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)       tb_dp_rd <= 1'b0;
    else if (HREADYOUT) tb_dp_rd <= HSEL & HTRANS[1] & ~HWRITE;
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (core_start) start_cnt++;
      if (core_abort) abort_cnt++;
      if (x_wvalid && x_wready) begin
        logic [31:0] e;
        checks++;
        if (wr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL operand_word unexpected actual=0x%08h expected=none", x_wdata);
        end else begin
          e = wr_exp_q.pop_front();
          if (x_wdata !== e) begin
            errors++;
            $display("FAIL operand_word actual=0x%08h expected=0x%08h", x_wdata, e);
          end
        end
      end
      if (tb_dp_rd && HREADYOUT) begin
        logic [31:0] e;
        checks++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_data unexpected actual=0x%08h expected=none", HRDATA);
        end else begin
          e = rd_exp_q.pop_front();
          if (HRDATA !== e) begin
            errors++;
            $display("FAIL read_data actual=0x%08h expected=0x%08h", HRDATA, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  // Entered at the start of a data phase (posedge + 1); returns one step
  // after the completing edge.
  task automatic wait_ready();
    int n = 0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    if (!HREADYOUT) begin
      checks++; errors++;
      $display("FAIL hready_timeout actual=0 expected=1");
    end
    tick();
  endtask

  task automatic ahb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sz, input logic done_pulse);
    addr_phase(wr, a, sz);
    tick();
    bus_idle();
    HWDATA = wd;
    if (done_pulse) core_done = 1'b1;
    wait_ready();
    core_done = 1'b0;
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    ahb_xfer(1'b0, a, 32'h0, 3'b010, 1'b0);
  endtask

  // Pipelined DATA writes of base, base+1, ...; word stall_idx sees
  // x_wready low for stall_n cycles.
  task automatic load_words(input int n, input logic [31:0] base, input int stall_idx,
                            input int stall_n);
    for (int k = 0; k < n; k++) wr_exp_q.push_back(base + 32'(k));
    for (int i = 0; i <= n; i++) begin
      if (i < n) addr_phase(1'b1, 32'h10, 3'b010);
      else bus_idle();
      if (i > 0) HWDATA = base + 32'(i - 1);
      if (i > 0 && (i - 1) == stall_idx) begin
        x_wready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge HCLK);
          check("stall_hreadyout", {31'b0, HREADYOUT}, 32'h0);
          tick();
        end
        x_wready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    HRESETn = 1'b0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0;
    HWDATA = 0; x_wready = 1'b1; core_done = 1'b0; r_rvalid = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_hresp", {30'b0, HRESP}, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_x_wvalid", {31'b0, x_wvalid}, 32'h0);
    check("rst_x_wdata", x_wdata, 32'h0);
    check("rst_core_start", {31'b0, core_start}, 32'h0);
    check("rst_core_abort", {31'b0, core_abort}, 32'h0);
    check("rst_r_rready", {31'b0, r_rready}, 32'h0);
    check("rst_state", {29'b0, dbg_state}, 32'h0);
    tick();
    HRESETn = 1'b1;
    tick();
    ahb_read(32'h04, 32'h0000_0000);

    // ---- full load with stall on word 10 ----
    ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, 1'b0);       // ARM + IE
    ahb_read(32'h00, 32'h0000_0002);
    ahb_read(32'h04, 32'h0000_0004);
    load_words(11, 32'h0, 10, 3);
    ahb_read(32'h04, 32'h0000_0B04);
    load_words(53, 32'd11, -1, 0);
    tick();
    check("start_after_load", 32'(start_cnt), 32'd1);
    ahb_read(32'h04, 32'h0000_0002);

    // ---- completion, IRQ, unload ----
    ridx = 0;
    tick();
    core_done = 1'b1;
    @(negedge HCLK);
    check("irq_same_cycle_done", {31'b0, IRQ}, 32'h0);
    tick();
    core_done = 1'b0;
    @(negedge HCLK);
    check("irq_after_done", {31'b0, IRQ}, 32'h1);
    tick();
    ahb_read(32'h04, 32'h0000_0001);
    for (int i = 0; i < 64; i++) begin
      ahb_read(32'h10, 32'hA500_0000 + 32'(i));
      if (i == 4) ahb_read(32'h04, 32'h0000_0501);
    end
    @(negedge HCLK);
    check("irq_after_unload", {31'b0, IRQ}, 32'h0);
    tick();
    ahb_read(32'h04, 32'h0000_0000);

    // ---- error cases ----
    ahb_xfer(1'b1, 32'h10, 32'h0000_DEAD, 3'b010, 1'b0); // DATA write in IDLE
    ahb_read(32'h04, 32'h0000_0008);
    ahb_read(32'h10, 32'h0000_0000);                     // DATA read in IDLE
    ahb_read(32'h04, 32'h0000_0008);
    ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, 1'b0);
    ahb_read(32'h04, 32'h0000_0004);
    load_words(2, 32'h100, -1, 0);
    ahb_xfer(1'b1, 32'h10, 32'h0000_BEEF, 3'b000, 1'b0); // byte write in LOAD
    ahb_read(32'h04, 32'h0000_020C);
    pulse_done();                                        // ignored outside RUN
    ahb_read(32'h04, 32'h0000_020C);
    ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, 1'b0);
    ahb_read(32'h04, 32'h0000_0004);

    // ---- ARM in RUN together with core_done ----
    load_words(64, 32'h200, -1, 0);
    tick();
    check("start_second_load", 32'(start_cnt), 32'd2);
    ahb_read(32'h04, 32'h0000_0002);
    ahb_xfer(1'b1, 32'h00, 32'h3, 3'b010, 1'b1);
    tick();
    check("abort_pulses", 32'(abort_cnt), 32'd1);
    ahb_read(32'h04, 32'h0000_0004);
    @(negedge HCLK);
    check("irq_after_abort", {31'b0, IRQ}, 32'h0);
    tick();

    // ---- reset in LOAD at count 20, mid data phase ----
    load_words(20, 32'h300, -1, 0);
    ahb_read(32'h04, 32'h0000_1404);
    addr_phase(1'b1, 32'h10, 3'b010);
    tick();
    bus_idle();
    HWDATA = 32'h0000_0314;
    x_wready = 1'b0;
    @(negedge HCLK);
    check("pre_rst_x_wvalid", {31'b0, x_wvalid}, 32'h1);
    tick();
    HRESETn = 1'b0;
    #2;
    check("mid_rst_x_wvalid", {31'b0, x_wvalid}, 32'h0);
    check("mid_rst_x_wdata", x_wdata, 32'h0);
    check("mid_rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("mid_rst_irq", {31'b0, IRQ}, 32'h0);
    check("mid_rst_core_abort", {31'b0, core_abort}, 32'h0);
    check("mid_rst_state", {29'b0, dbg_state}, 32'h0);
    tick();
    x_wready = 1'b1;
    HRESETn = 1'b1;
    tick();
    check("abort_after_reset", 32'(abort_cnt), 32'd1);
    ahb_read(32'h04, 32'h0000_0000);
    ahb_read(32'h00, 32'h0000_0000);

    repeat (2) tick();
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
